// File: rtl/ddr_req_responder.sv
// Responder for the DDR2 traffic-gen request interface: counts accepted write/read requests
// and drains them one command at a time to the memory port. Optional stats: DDR_RESP_STATS_EN.
module ddr_req_responder #(
  parameter  int WQ_DEPTH = 4,
  parameter  int RQ_DEPTH = 4,
  localparam int CW = $clog2(((WQ_DEPTH > RQ_DEPTH) ? WQ_DEPTH : RQ_DEPTH) + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          mode,
  input  logic          write_req,
  input  logic          read_req,
  output logic          write_allowed,
  output logic          read_allowed,
  output logic          writes_pending,
  output logic          reads_pending,
  output logic [CW-1:0] wr_count,
  output logic [CW-1:0] rd_count,
  output logic          mem_cmd_valid,
  output logic          mem_cmd_wr,
  input  logic          mem_cmd_ready,
  input  logic          mem_done,
`ifdef DDR_RESP_STATS_EN
  output logic [31:0]   wr_accepted,
  output logic [31:0]   rd_accepted,
  output logic [31:0]   stall_cycles,
`endif
  output logic          req_dropped
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE} state_t;

  localparam logic [CW-1:0] WQ_MAX = CW'(WQ_DEPTH);
  localparam logic [CW-1:0] RQ_MAX = CW'(RQ_DEPTH);
  localparam logic [CW-1:0] ONE    = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] wr_count_q, wr_count_d;
  logic [CW-1:0] rd_count_q, rd_count_d;
  logic          cur_wr_q, cur_wr_d;
  logic          last_wr_q, last_wr_d;
  logic          valid_q, valid_d;
  logic          cmd_wr_q, cmd_wr_d;
  logic          dropped_q, dropped_d;

  logic wr_acc, rd_acc, wr_ret, rd_ret, sel_wr;

  assign write_allowed  = enable & ~reset & (wr_count_q != WQ_MAX);
  assign read_allowed   = enable & ~reset & (rd_count_q != RQ_MAX);
  assign writes_pending = (wr_count_q != '0);
  assign reads_pending  = (rd_count_q != '0);
  assign wr_count       = wr_count_q;
  assign rd_count       = rd_count_q;
  assign mem_cmd_valid  = valid_q;
  assign mem_cmd_wr     = cmd_wr_q;
  assign req_dropped    = dropped_q;

  always_comb begin
    wr_acc     = write_req & write_allowed;
    rd_acc     = read_req & read_allowed;
    wr_ret     = (state_q == WAIT_DONE) & mem_done & cur_wr_q;
    rd_ret     = (state_q == WAIT_DONE) & mem_done & ~cur_wr_q;
    wr_count_d = wr_count_q;
    rd_count_d = rd_count_q;
    state_d    = state_q;
    cur_wr_d   = cur_wr_q;
    last_wr_d  = last_wr_q;
    valid_d    = valid_q;
    cmd_wr_d   = cmd_wr_q;
    dropped_d  = dropped_q | (write_req & ~write_allowed) | (read_req & ~read_allowed);
    sel_wr     = 1'b0;

    if (wr_acc && !wr_ret)      wr_count_d = wr_count_q + ONE;
    else if (!wr_acc && wr_ret) wr_count_d = wr_count_q - ONE;
    if (rd_acc && !rd_ret)      rd_count_d = rd_count_q + ONE;
    else if (!rd_acc && rd_ret) rd_count_d = rd_count_q - ONE;

    case (state_q)
      IDLE: begin
        // Nothing is in flight in IDLE, so the counts are exactly the queued work.
        if (wr_count_q != '0 || rd_count_q != '0) begin
          if (wr_count_q == '0)      sel_wr = 1'b0;
          else if (rd_count_q == '0) sel_wr = 1'b1;
          else                       sel_wr = mode ? 1'b1 : ~last_wr_q;
          valid_d   = 1'b1;
          cmd_wr_d  = sel_wr;
          cur_wr_d  = sel_wr;
          last_wr_d = sel_wr;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_cmd_ready) begin
          valid_d = 1'b0;
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mem_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      wr_count_q <= '0;
      rd_count_q <= '0;
      cur_wr_q   <= 1'b0;
      last_wr_q  <= 1'b0;
      valid_q    <= 1'b0;
      cmd_wr_q   <= 1'b0;
      dropped_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      cur_wr_q   <= cur_wr_d;
      last_wr_q  <= last_wr_d;
      valid_q    <= valid_d;
      cmd_wr_q   <= cmd_wr_d;
      dropped_q  <= dropped_d;
    end
  end

`ifdef DDR_RESP_STATS_EN
  logic [31:0] wr_acc_q, wr_acc_d, rd_acc_q, rd_acc_d, stall_q, stall_d;

  always_comb begin
    wr_acc_d = wr_acc_q + {31'd0, wr_acc};
    rd_acc_d = rd_acc_q + {31'd0, rd_acc};
    stall_d  = stall_q + {31'd0, (state_q == ISSUE) & ~mem_cmd_ready};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_acc_q <= '0;
      rd_acc_q <= '0;
      stall_q  <= '0;
    end else begin
      wr_acc_q <= wr_acc_d;
      rd_acc_q <= rd_acc_d;
      stall_q  <= stall_d;
    end
  end

  assign wr_accepted  = wr_acc_q;
  assign rd_accepted  = rd_acc_q;
  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ddr_req_responder.sv
// Directed table-driven bench for ddr_req_responder (default depths 4/4).
module tb_ddr_req_responder;

  logic       clk = 1'b0;
  logic       reset, enable, mode, write_req, read_req, mem_cmd_ready, mem_done;
  logic       write_allowed, read_allowed, writes_pending, reads_pending;
  logic       mem_cmd_valid, mem_cmd_wr, req_dropped;
  logic [2:0] wr_count, rd_count;
`ifdef DDR_RESP_STATS_EN
  logic [31:0] wr_accepted, rd_accepted, stall_cycles;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  ddr_req_responder dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode),
    .write_req(write_req), .read_req(read_req),
    .write_allowed(write_allowed), .read_allowed(read_allowed),
    .writes_pending(writes_pending), .reads_pending(reads_pending),
    .wr_count(wr_count), .rd_count(rd_count),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_ready(mem_cmd_ready), .mem_done(mem_done),
`ifdef DDR_RESP_STATS_EN
    .wr_accepted(wr_accepted), .rd_accepted(rd_accepted), .stall_cycles(stall_cycles),
`endif
    .req_dropped(req_dropped)
  );

  typedef struct {
    logic       en, w, r, rdy, done;
    logic [2:0] wr, rd;
    logic       v, cw, wal, drop;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive inputs, take one rising edge, then return at the falling edge for sampling.
  task automatic step(input logic en, input logic w, input logic r, input logic rdy, input logic done);
    enable = en; write_req = w; read_req = r; mem_cmd_ready = rdy; mem_done = done;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) step(0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic fill_3x3();
    repeat (3) step(1, 1, 1, 0, 0);
  endtask

  task automatic serve6(output logic [5:0] ord, output int got);
    ord = '0;
    got = 0;
    for (int c = 0; c < 60 && got < 6; c++) begin
      if (mem_cmd_valid) begin
        ord[got] = mem_cmd_wr;
        got++;
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 0, 1);
      end else begin
        step(1, 0, 0, 0, 0);
      end
    end
  endtask

  initial begin
    logic [5:0] ord;
    int         got;
    int         stable_ok;

    reset = 1'b1; enable = 1'b0; mode = 1'b0; write_req = 1'b0; read_req = 1'b0;
    mem_cmd_ready = 1'b0; mem_done = 1'b0;
    @(negedge clk);

    //             en w  r  rdy dn  wr    rd    v  cw wal drop
    tbl[0]  = '{1, 1, 0, 0, 0, 3'd1, 3'd0, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 0, 0, 3'd1, 3'd0, 1, 1, 1, 0};
    tbl[2]  = '{1, 0, 1, 0, 0, 3'd1, 3'd1, 1, 1, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 0, 3'd1, 3'd1, 0, 1, 1, 0};
    tbl[4]  = '{1, 1, 0, 0, 1, 3'd1, 3'd1, 0, 1, 1, 0};
    tbl[5]  = '{1, 0, 0, 0, 0, 3'd1, 3'd1, 1, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 1, 0, 3'd1, 3'd1, 0, 0, 1, 0};
    tbl[7]  = '{1, 0, 0, 0, 0, 3'd1, 3'd1, 0, 0, 1, 0};
    tbl[8]  = '{1, 0, 0, 0, 1, 3'd1, 3'd0, 0, 0, 1, 0};
    tbl[9]  = '{0, 1, 0, 0, 0, 3'd1, 3'd0, 1, 1, 0, 1};
    tbl[10] = '{1, 0, 0, 1, 0, 3'd1, 3'd0, 0, 1, 1, 1};
    tbl[11] = '{1, 0, 0, 0, 1, 3'd0, 3'd0, 0, 1, 1, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 3'd0, 3'd0, 0, 1, 1, 1};

    // Reset held three cycles, then idle with enable high.
    do_reset();
    chk("rst_wr_count", {29'd0, wr_count}, 32'd0);
    chk("rst_valid", {31'd0, mem_cmd_valid}, 32'd0);
    chk("rst_dropped", {31'd0, req_dropped}, 32'd0);
`ifdef DDR_RESP_STATS_EN
    chk("rst_stall", stall_cycles, 32'd0);
`endif
    step(1, 0, 0, 0, 0);
    chk("idle_wal", {31'd0, write_allowed}, 32'd1);
    chk("idle_ral", {31'd0, read_allowed}, 32'd1);
    chk("idle_wpend", {31'd0, writes_pending}, 32'd0);
    chk("idle_rpend", {31'd0, reads_pending}, 32'd0);
    chk("idle_valid", {31'd0, mem_cmd_valid}, 32'd0);

    // Table: single write, a read behind it, accept+retire, enable low drop.
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].en, tbl[i].w, tbl[i].r, tbl[i].rdy, tbl[i].done);
      chk($sformatf("t%0d_wr_count", i), {29'd0, wr_count}, {29'd0, tbl[i].wr});
      chk($sformatf("t%0d_rd_count", i), {29'd0, rd_count}, {29'd0, tbl[i].rd});
      chk($sformatf("t%0d_valid", i), {31'd0, mem_cmd_valid}, {31'd0, tbl[i].v});
      chk($sformatf("t%0d_cmd_wr", i), {31'd0, mem_cmd_wr}, {31'd0, tbl[i].cw});
      chk($sformatf("t%0d_wal", i), {31'd0, write_allowed}, {31'd0, tbl[i].wal});
      chk($sformatf("t%0d_dropped", i), {31'd0, req_dropped}, {31'd0, tbl[i].drop});
      chk($sformatf("t%0d_wpend", i), {31'd0, writes_pending}, {31'd0, (tbl[i].wr != 3'd0)});
    end

    // Fill the write queue while memory stalls; command must stay offered.
    do_reset();
    stable_ok = 1;
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 0);
      if (i >= 1 && !(mem_cmd_valid === 1'b1 && mem_cmd_wr === 1'b1)) stable_ok = 0;
    end
    chk("full_stable_valid", stable_ok, 1);
    chk("full_wr_count", {29'd0, wr_count}, 32'd4);
    chk("full_wal", {31'd0, write_allowed}, 32'd0);
    chk("full_dropped", {31'd0, req_dropped}, 32'd1);
`ifdef DDR_RESP_STATS_EN
    chk("full_wr_accepted", wr_accepted, 32'd4);
    chk("full_stall", stall_cycles, 32'd4);
`endif

    // Retire at full with a blocked request, then accept the freed slot.
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1);
    chk("full_retire_count", {29'd0, wr_count}, 32'd3);
    step(1, 1, 0, 0, 0);
    chk("refill_count", {29'd0, wr_count}, 32'd4);
    chk("refill_valid", {31'd0, mem_cmd_valid}, 32'd1);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1);
    chk("drain_to_2", {29'd0, wr_count}, 32'd2);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    step(1, 1, 0, 0, 1);
    chk("acc_ret_at_2", {29'd0, wr_count}, 32'd2);

    // Reset while a write waits for completion with counts 2/1.
    step(1, 0, 1, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("pre_rst_wr", {29'd0, wr_count}, 32'd2);
    chk("pre_rst_rd", {29'd0, rd_count}, 32'd1);
    reset = 1'b1;
    step(1, 0, 0, 0, 0);
    chk("mid_rst_wr", {29'd0, wr_count}, 32'd0);
    chk("mid_rst_rd", {29'd0, rd_count}, 32'd0);
    chk("mid_rst_valid", {31'd0, mem_cmd_valid}, 32'd0);
    chk("mid_rst_wal", {31'd0, write_allowed}, 32'd0);
`ifdef DDR_RESP_STATS_EN
    chk("mid_rst_wr_acc", wr_accepted, 32'd0);
    chk("mid_rst_stall", stall_cycles, 32'd0);
`endif
    reset = 1'b0;
    step(1, 0, 0, 0, 0);
    chk("post_rst_valid", {31'd0, mem_cmd_valid}, 32'd0);
    chk("post_rst_wal", {31'd0, write_allowed}, 32'd1);

    // Arbitration order: alternate, then write priority.
    mode = 1'b0;
    do_reset();
    fill_3x3();
    serve6(ord, got);
    chk("alt_served", got, 6);
    chk("alt_order", {26'd0, ord}, 32'b010101);
    chk("alt_empty", {26'd0, wr_count, rd_count}, 32'd0);

    mode = 1'b1;
    do_reset();
    fill_3x3();
    serve6(ord, got);
    chk("prio_served", got, 6);
    chk("prio_order", {26'd0, ord}, 32'b000111);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
